// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command-frame controller with 16x8 register file
module uart_cmd_ctrl #(
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter int         TIMEOUT_CYC = 208320,
    parameter int         ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             wr_en,
    output logic [3:0]       wr_addr,
    output logic [7:0]       wr_data,
    input  logic [3:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic             busy,
    output logic             frame_err,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    localparam int               GAP_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state;
    logic [GAP_W-1:0] gap;
    logic [7:0]       addr_byte;
    logic [7:0]       data_byte;
    logic [7:0]       csum;
    logic [7:0]       regs [16];

    // Checksum is the 8-bit wrapping sum of the address and data bytes
    assign csum    = addr_byte + data_byte;
    assign busy    = (state != S_IDLE);
    assign rd_data = regs[rd_addr];

    // Frame sequencer, gap timer, error counter and register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gap       <= '0;
            addr_byte <= '0;
            data_byte <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            err_cnt   <= '0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                S_IDLE, S_COMMIT: begin
                    gap <= '0;
                    // wr_addr/wr_data were loaded on entry to COMMIT
                    if (state == S_COMMIT) begin
                        regs[wr_addr] <= wr_data;
                    end
                    if (rx_valid && rx_data == HEADER) begin
                        state <= S_ADDR;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ADDR, S_DATA, S_CSUM: begin
                    // A byte arriving on the expiry cycle still counts
                    if (rx_valid) begin
                        gap <= '0;
                        if (state == S_ADDR) begin
                            addr_byte <= rx_data;
                            state     <= S_DATA;
                        end else if (state == S_DATA) begin
                            data_byte <= rx_data;
                            state     <= S_CSUM;
                        end else if (rx_data == csum && addr_byte[7:4] == 4'h0) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr_byte[3:0];
                            wr_data <= data_byte;
                            state   <= S_COMMIT;
                        end else begin
                            frame_err <= 1'b1;
                            if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            state <= S_IDLE;
                        end
                    end else if (gap == GAP_LAST) begin
                        timeout <= 1'b1;
                        if (err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        gap   <= '0;
                        state <= S_IDLE;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: begin
                    gap   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command-frame controller sitting directly behind the UART receiver. It consumes the receiver's one-cycle byte strobes and sequences 4-byte write frames: header, address, data, checksum. Validated frames commit into an internal 16x8 register file. The register file drives the board's control logic through a combinational read port, and the block also provides error and timeout reporting.

Parameters:
HEADER, 8'hAA, frame start byte
TIMEOUT_CYC, 208320, max clk cycles allowed between bytes inside a frame (about 2 byte times at 9600 baud, 100 MHz); bench overrides to a small value
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle byte strobe from UART receiver
rx_data  in  8  received byte, valid while rx_valid=1
wr_en  out  1  one-cycle pulse when a frame commits
wr_addr  out  4  committed register address
wr_data  out  8  committed register data
rd_addr  in  4  register file read address
rd_data  out  8  combinational read of regs[rd_addr]
busy  out  1  high in any state other than IDLE
frame_err  out  1  one-cycle pulse on checksum or address error
timeout  out  1  one-cycle pulse on inter-byte timeout
err_cnt  out  ERR_W  saturating count of frame_err and timeout events

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE
  - wr_en, frame_err, timeout = 0
  - wr_addr=0, wr_data=0, err_cnt=0
  - all 16 regs=0
  - gap counter=0, internal addr/data latches=0
- States and transitions:
  - IDLE: on rx_valid with rx_data==HEADER, go to ADDR. Any other byte is silently ignored; no error is raised.
  - ADDR: on rx_valid, latch addr_byte=rx_data and go to DATA. A HEADER value here is treated as an address; there is no resync.
  - DATA: on rx_valid, latch data_byte and go to CSUM.
  - CSUM: on rx_valid:
    - Compute sum=(addr_byte+data_byte) mod 256, 8-bit wrap.
    - If rx_data==sum and addr_byte[7:4]==0, go to COMMIT.
    - Otherwise pulse frame_err for 1 cycle, increment err_cnt, and go to IDLE.
  - COMMIT: lasts exactly 1 cycle.
    - wr_en=1, wr_addr=addr_byte[3:0], wr_data=data_byte.
    - regs[wr_addr] takes wr_data on the edge leaving COMMIT; next state is IDLE.
    - If rx_valid is asserted during COMMIT, it is evaluated as IDLE would (HEADER goes to ADDR, else dropped).
- Latency:
  - Checksum strobe in cycle N gives wr_en high in N+1.
  - rd_data reflects the new value from N+2.
  - A rejected frame pulses frame_err in N+1.
- wr_addr/wr_data hold their last committed values after wr_en drops.
- Timeout:
  - The gap counter clears on every accepted rx_valid and while in IDLE.
  - It increments each cycle in ADDR/DATA/CSUM.
  - When it reaches TIMEOUT_CYC-1 without a byte: pulse timeout for 1 cycle, increment err_cnt, return to IDLE, discard the partial frame.
  - If rx_valid arrives in the same cycle as expiry, the byte wins; no timeout.
- err_cnt saturates at 2^ERR_W-1 and never wraps. When frame_err and timeout could coincide, only one event is raised (they are mutually exclusive by state).
- busy = (state != IDLE).
- rd_data is combinational from regs. Reading the address being committed returns the old value during COMMIT and the new value afterwards.
- Reset mid-frame: the partial frame is discarded, regs clear to 0, and no wr_en is issued.
- Unused state encodings recover to IDLE.

Test Plan:
- Frame AA 03 5A 5D (sum 0x5D) -> wr_en pulse 1 cycle, wr_addr=3, wr_data=0x5A; rd_addr=3 gives 0x5A from N+2; err_cnt=0.
- Frame AA 07 FF 06 (8-bit wrap of 0x106) -> commit regs[7]=0xFF. Then AA 07 01 09 (bad sum, expected 0x08) -> frame_err pulse, err_cnt=1, regs[7] stays 0xFF.
- Frame AA 13 10 23 (addr upper nibble set, correct sum) -> frame_err, no wr_en, err_cnt increments.
- TIMEOUT_CYC=50: send AA 02 then idle 60 cycles -> timeout pulses at cycle 50 after byte 02, busy falls, err_cnt increments. Then AA 02 11 13 -> regs[2]=0x11.
- Bytes 00 55 FF before AA 01 22 23 -> garbage ignored with no error; regs[1]=0x22.
- Assert rst after AA 04 -> all outputs and regs 0, state IDLE. Force 300 bad frames -> err_cnt holds at 255.
